// File: rtl/bcd_bin_decoder.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one result bit per clock.
// Captures a packed BCD word on start, pulses done with the binary value or an invalid-digit flag.
module bcd_bin_decoder #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  if (pow10(DIGITS) > (64'd1 << BIN_W)) begin : g_width_check
    $error("bcd_bin_decoder: BIN_W too narrow for DIGITS decimal digits");
  end

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // After a right shift a digit >= 8 has received a weight-10 bit that must become weight-5.
  function automatic logic [BCD_W-1:0] correct_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] >= 4'd8) ? (v[4*i +: 4] - 4'd3) : v[4*i +: 4];
    end
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_out_q, bin_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Next-state, datapath and output decode
  always_comb begin
    state_d   = state_q;
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    err_d     = err_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          bcd_d = bcd_in;
          bin_d = '0;
          cnt_d = '0;
          if (has_bad_digit(bcd_in)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = S_SHIFT;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        bin_d = {bcd_q[0], bin_q[BIN_W-1:1]};
        bcd_d = correct_digits({1'b0, bcd_q[BCD_W-1:1]});
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_d == CNT_W'(BIN_W)) begin
          state_d   = S_DONE;
          bin_out_d = bin_d;
          err_d     = 1'b0;
          done_d    = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bin_out = bin_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
